// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM side signals of the shared single-port memory arbiter.
// slave  : seen by the arbiter
// master : seen by the requesters and the RAM model
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Instruction fetch (read only)
  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic [DATA_W-1:0] f_rdata;
  logic              f_ack;
  // CPU data load/store
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  // External debug/IO port
  logic              x_req;
  logic              x_we;
  logic [ADDR_W-1:0] x_addr;
  logic [DATA_W-1:0] x_wdata;
  logic [DATA_W-1:0] x_rdata;
  logic              x_ack;
  // RAM port
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  // Status
  logic [1:0]        grant_id;
  logic              busy;

  modport slave (
    input  f_req, f_addr,
    output f_rdata, f_ack,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_ack,
    input  x_req, x_we, x_addr, x_wdata,
    output x_rdata, x_ack,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output grant_id, busy
  );

  modport master (
    output f_req, f_addr,
    input  f_rdata, f_ack,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_ack,
    output x_req, x_we, x_addr, x_wdata,
    input  x_rdata, x_ack,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  grant_id, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the block RAM shared by fetch (F), CPU data (D)
// and the external port (X). One access at a time, IDLE -> ISSUE -> RESP,
// completion reported with a registered one-cycle ack per requester.
module mem_port_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] ID_NONE    = 2'd0;
  localparam logic [1:0] ID_F       = 2'd1;
  localparam logic [1:0] ID_D       = 2'd2;
  localparam logic [1:0] ID_X       = 2'd3;
  localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              we_q, we_d;
  logic [7:0]        starve_q, starve_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic [1:0]        grant_q, grant_d;
  logic              busy_q, busy_d;
  // Index 0 = F, 1 = D, 2 = X
  logic [2:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q [3];
  logic [DATA_W-1:0] rdata_d [3];

  logic [2:0]        req_eff;
  logic [1:0]        winner;

  // A request still high during its own ack cycle is the finished access, not a new one
  assign req_eff = {bus.x_req & ~ack_q[2], bus.d_req & ~ack_q[1], bus.f_req & ~ack_q[0]};

  // Priority D > F > X, except a starved X that has hit its loss limit
  always_comb begin
    winner = ID_NONE;
    if (req_eff[2] && starve_q == STARVE_MAX) winner = ID_X;
    else if (req_eff[1])                      winner = ID_D;
    else if (req_eff[0])                      winner = ID_F;
    else if (req_eff[2])                      winner = ID_X;
  end

  // Next state, access latches, starve counter and registered outputs
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    starve_d    = bus.x_req ? starve_q : 8'd0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    grant_d     = grant_q;
    busy_d      = busy_q;
    ack_d       = 3'b000;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        mem_we_d = 1'b0;
        grant_d  = ID_NONE;
        busy_d   = 1'b0;
        if (winner == ID_X) begin
          starve_d = 8'd0;
        end else if (winner != ID_NONE && req_eff[2] && starve_q < STARVE_MAX) begin
          starve_d = starve_q + 8'd1;
        end
        if (winner != ID_NONE) begin
          state_d = ISSUE;
          owner_d = winner;
          grant_d = winner;
          busy_d  = 1'b1;
          case (winner)
            ID_F: begin
              mem_addr_d = bus.f_addr;
              we_d       = 1'b0;
            end
            ID_D: begin
              mem_addr_d  = bus.d_addr;
              mem_wdata_d = bus.d_wdata;
              we_d        = bus.d_we;
            end
            default: begin
              mem_addr_d  = bus.x_addr;
              mem_wdata_d = bus.x_wdata;
              we_d        = bus.x_we;
            end
          endcase
          mem_we_d = we_d;
        end
      end
      ISSUE: begin
        state_d  = RESP;
        mem_we_d = 1'b0;
      end
      RESP: begin
        state_d = IDLE;
        grant_d = ID_NONE;
        busy_d  = 1'b0;
        for (int i = 0; i < 3; i++) begin
          if (owner_q == 2'(i + 1)) begin
            ack_d[i] = 1'b1;
            if (!we_q) rdata_d[i] = bus.mem_rdata;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        mem_we_d = 1'b0;
        grant_d  = ID_NONE;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= ID_NONE;
      we_q        <= 1'b0;
      starve_q    <= 8'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      grant_q     <= ID_NONE;
      busy_q      <= 1'b0;
      ack_q       <= 3'b000;
      for (int i = 0; i < 3; i++) rdata_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      grant_q     <= grant_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      for (int i = 0; i < 3; i++) rdata_q[i] <= rdata_d[i];
    end
  end

  assign bus.f_ack     = ack_q[0];
  assign bus.d_ack     = ack_q[1];
  assign bus.x_ack     = ack_q[2];
  assign bus.f_rdata   = rdata_q[0];
  assign bus.d_rdata   = rdata_q[1];
  assign bus.x_rdata   = rdata_q[2];
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LIM = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Synchronous RAM: read data valid the cycle after the address
  logic [DW-1:0] ram [0:255];
  logic          pre_we = 1'b0;
  logic [7:0]    pre_addr = 8'd0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end

  int checks = 0;
  int failures = 0;

  // Reference model: memory contents plus the access currently in service
  logic [DW-1:0] mmem [0:255];
  int            m_left = 0;     // cycles of the granted access still to come
  int            m_owner = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wd = '0;
  logic [DW-1:0] m_exp = '0;
  logic [DW-1:0] m_old = '0;
  int            m_starve = 0;
  logic [3:1]    m_ack = 3'b000;
  logic [DW-1:0] m_rd [1:3];
  int            m_grant = 0;
  logic          m_memwe = 1'b0;
  logic          m_busy = 1'b0;
  logic          m_issue = 1'b0;

  int ack_n [1:3];
  int ack_at [1:3];
  int we_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    if (m_left > 0 && m_we) mmem[m_addr[7:0]] = m_old;  // aborted write never reached RAM
    m_left = 0; m_starve = 0; m_ack = 3'b000;
    m_grant = 0; m_memwe = 1'b0; m_busy = 1'b0; m_issue = 1'b0;
    for (int r = 1; r <= 3; r++) m_rd[r] = '0;
  endtask

  // Decide what the arbiter must show after the coming clock edge
  task automatic predict();
    logic [3:1] nack;
    logic ef, ed, ex;
    int w;
    nack = 3'b000;
    m_issue = 1'b0;
    if (m_left == 0) begin
      ef = bus.f_req && !m_ack[1];
      ed = bus.d_req && !m_ack[2];
      ex = bus.x_req && !m_ack[3];
      w = 0;
      if (ex && m_starve == LIM) w = 3;
      else if (ed) w = 2;
      else if (ef) w = 1;
      else if (ex) w = 3;
      if (!bus.x_req || w == 3) m_starve = 0;
      else if (ex && w != 0 && m_starve < LIM) m_starve++;
      if (w != 0) begin
        m_owner = w; m_left = 2; m_issue = 1'b1;
        case (w)
          1: begin m_we = 1'b0; m_addr = bus.f_addr; end
          2: begin m_we = bus.d_we; m_addr = bus.d_addr; m_wd = bus.d_wdata; end
          default: begin m_we = bus.x_we; m_addr = bus.x_addr; m_wd = bus.x_wdata; end
        endcase
        m_old = mmem[m_addr[7:0]];
        if (m_we) mmem[m_addr[7:0]] = m_wd;
        else m_exp = m_old;
        m_grant = w; m_memwe = m_we; m_busy = 1'b1;
      end else begin
        m_grant = 0; m_memwe = 1'b0; m_busy = 1'b0;
      end
    end else begin
      if (!bus.x_req) m_starve = 0;
      if (m_left == 2) begin
        m_memwe = 1'b0;
        m_left = 1;
      end else begin
        nack[m_owner] = 1'b1;
        if (!m_we) m_rd[m_owner] = m_exp;
        m_grant = 0; m_busy = 1'b0; m_left = 0;
      end
    end
    m_ack = nack;
  endtask

  task automatic check_outputs();
    chk("f_ack", bus.f_ack, m_ack[1]);
    chk("d_ack", bus.d_ack, m_ack[2]);
    chk("x_ack", bus.x_ack, m_ack[3]);
    chk("f_rdata", bus.f_rdata, m_rd[1]);
    chk("d_rdata", bus.d_rdata, m_rd[2]);
    chk("x_rdata", bus.x_rdata, m_rd[3]);
    chk("grant_id", bus.grant_id, m_grant);
    chk("busy", bus.busy, m_busy);
    chk("mem_we", bus.mem_we, m_memwe);
    if (m_issue) begin
      chk("mem_addr", bus.mem_addr, m_addr);
      if (m_we) chk("mem_wdata", bus.mem_wdata, m_wd);
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_req(input int r, input logic v);
    case (r)
      1: bus.f_req = v;
      2: bus.d_req = v;
      default: bus.x_req = v;
    endcase
  endtask

  task automatic new_fields(input int r);
    logic [AW-1:0] a;
    a = AW'($urandom_range(0, 31));
    case (r)
      1: bus.f_addr = a;
      2: begin bus.d_addr = a; bus.d_we = 1'($urandom_range(0, 1)); bus.d_wdata = DW'($urandom); end
      default: begin bus.x_addr = a; bus.x_we = 1'($urandom_range(0, 1)); bus.x_wdata = DW'($urandom); end
    endcase
  endtask

  function automatic logic ack_of(input int r);
    case (r)
      1: return bus.f_ack;
      2: return bus.d_ack;
      default: return bus.x_ack;
    endcase
  endfunction

  function automatic logic req_of(input int r);
    case (r)
      1: return bus.f_req;
      2: return bus.d_req;
      default: return bus.x_req;
    endcase
  endfunction

  // Run up to maxc cycles; requesters in drop drop their request on ack
  task automatic run(input int maxc, input logic [3:1] drop, input bit until_idle, input bit until_x);
    int n;
    bit done;
    n = 0; done = 0; we_cnt = 0;
    for (int r = 1; r <= 3; r++) begin ack_n[r] = 0; ack_at[r] = 0; end
    while (!done && n < maxc) begin
      tick();
      n++;
      if (bus.mem_we) we_cnt++;
      for (int r = 1; r <= 3; r++) begin
        if (ack_of(r)) begin
          ack_n[r]++;
          if (ack_at[r] == 0) ack_at[r] = n;
          if (drop[r]) set_req(r, 1'b0);
        end
      end
      if (until_idle && !bus.f_req && !bus.d_req && !bus.x_req && m_left == 0) done = 1;
      if (until_x && ack_n[3] > 0) done = 1;
    end
    if (until_idle || until_x) chk("run_bound", done, 1);
  endtask

  initial begin
    logic [DW-1:0] v;
    bus.f_req = 0; bus.f_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.x_req = 0; bus.x_we = 0; bus.x_addr = '0; bus.x_wdata = '0;
    m_reset();

    // Preload RAM and model while reset is held
    for (int i = 0; i < 256; i++) begin
      v = (i == 16) ? 16'hBEEF : (i == 32) ? 16'h1234 : DW'($urandom);
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 8'(i); pre_data = v;
      mmem[i] = v;
    end
    @(negedge clk);
    pre_we = 1'b0;

    // Reset state
    chk("rst_f_ack", bus.f_ack, 0);   chk("rst_d_ack", bus.d_ack, 0);
    chk("rst_x_ack", bus.x_ack, 0);   chk("rst_f_rdata", bus.f_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0); chk("rst_x_rdata", bus.x_rdata, 0);
    chk("rst_mem_addr", bus.mem_addr, 0); chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_we", bus.mem_we, 0); chk("rst_grant", bus.grant_id, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b1;
    run(2, 3'b111, 0, 0);

    // Fetch read with fixed latency
    bus.f_addr = 16'h0010; bus.f_req = 1;
    run(10, 3'b111, 1, 0);
    chk("t1_f_ack_n", ack_n[1], 1);
    chk("t1_f_ack_at", ack_at[1], 3);
    chk("t1_f_rdata", bus.f_rdata, 16'hBEEF);
    run(2, 3'b111, 0, 0);

    // D beats F; F follows three cycles later
    bus.f_addr = 16'h0010; bus.f_req = 1;
    bus.d_addr = 16'h0020; bus.d_we = 0; bus.d_req = 1;
    run(20, 3'b111, 1, 0);
    chk("t2_d_ack_at", ack_at[2], 3);
    chk("t2_f_ack_at", ack_at[1], 6);
    chk("t2_d_ack_n", ack_n[2], 1);
    chk("t2_d_rdata", bus.d_rdata, 16'h1234);
    run(2, 3'b111, 0, 0);

    // Store then load back
    bus.d_addr = 16'h0030; bus.d_we = 1; bus.d_wdata = 16'hA5A5; bus.d_req = 1;
    run(10, 3'b111, 1, 0);
    chk("t3_we_cycles", we_cnt, 1);
    chk("t3_d_rdata_kept", bus.d_rdata, 16'h1234);
    run(2, 3'b111, 0, 0);
    bus.d_we = 0; bus.d_req = 1;
    run(10, 3'b111, 1, 0);
    chk("t3_d_rdata_load", bus.d_rdata, 16'hA5A5);
    run(2, 3'b111, 0, 0);

    // Starvation: X wins the ninth arbitration under continuous D/F load
    bus.d_addr = 16'h0020; bus.d_we = 0; bus.d_req = 1;
    bus.f_addr = 16'h0010; bus.f_req = 1;
    bus.x_addr = 16'h0040; bus.x_we = 0; bus.x_req = 1;
    run(9 * 3 + 3, 3'b100, 0, 1);
    chk("t4_x_ack_at", ack_at[3], 27);
    chk("t4_x_rdata", bus.x_rdata, mmem[8'h40]);
    bus.d_req = 0; bus.f_req = 0;
    run(20, 3'b111, 1, 0);
    run(2, 3'b111, 0, 0);

    // Held fetch request: one grant per ack, ack cycle not re-granted
    bus.f_addr = 16'h0010; bus.f_req = 1;
    run(16, 3'b000, 0, 0);
    chk("t6_f_ack_n", ack_n[1], 4);
    chk("t6_f_ack_at", ack_at[1], 3);
    bus.f_req = 0;
    run(10, 3'b111, 1, 0);
    run(2, 3'b111, 0, 0);

    // Reset during an X write in ISSUE
    bus.x_addr = 16'h0050; bus.x_we = 1; bus.x_wdata = 16'h5A5A; bus.x_req = 1;
    tick();
    chk("t5_issue_we", bus.mem_we, 1);
    #2 reset = 1'b0;
    #1;
    chk("t5_mem_we", bus.mem_we, 0);   chk("t5_x_ack", bus.x_ack, 0);
    chk("t5_grant", bus.grant_id, 0);  chk("t5_busy", bus.busy, 0);
    chk("t5_mem_addr", bus.mem_addr, 0); chk("t5_mem_wdata", bus.mem_wdata, 0);
    chk("t5_d_rdata", bus.d_rdata, 0); chk("t5_f_rdata", bus.f_rdata, 0);
    m_reset();
    bus.x_req = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run(5, 3'b111, 0, 0);
    bus.x_we = 0; bus.x_req = 1;
    run(10, 3'b111, 1, 0);
    chk("t5_x_rdata", bus.x_rdata, mmem[8'h50]);

    // Random traffic; owners scramble their inputs after grant
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int r = 1; r <= 3; r++) begin
        if (ack_of(r)) begin
          if ($urandom_range(0, 1) == 1) new_fields(r);
          else set_req(r, 1'b0);
        end else if (!req_of(r)) begin
          if ($urandom_range(0, 9) < 3) begin
            new_fields(r);
            set_req(r, 1'b1);
          end
        end else if (m_left > 0 && m_owner == r && $urandom_range(0, 3) == 0) begin
          new_fields(r);
        end
      end
    end
    run(200, 3'b111, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbiter and sequencer for the single-port synchronous block RAM shared by the CPU and an external port. The three requesters are:
- instruction fetch (F)
- CPU data load/store (D)
- external debug/IO port (X)

The block grants one access at a time, drives the RAM port for that access, and returns read data with a one-cycle acknowledge pulse. It sits between the fetch/decode/execute control FSM, the load/store path and the RAM.

Parameters:
ADDR_W, 16, address width of RAM and all requesters
DATA_W, 16, data word width
STARVE_LIMIT, 8, consecutive arbitrations X may lose before X is forced to win (range 1-255)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
f_req  in  1  fetch read request; held high until f_ack
f_addr  in  ADDR_W  fetch address
f_rdata  out  DATA_W  fetch read data; valid while f_ack=1
f_ack  out  1  one-cycle completion pulse for F
d_req  in  1  data request; held until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data; valid while d_ack=1
d_ack  out  1  completion pulse for D
x_req  in  1  external request; held until x_ack
x_we  in  1  1=write, 0=read
x_addr  in  ADDR_W  external address
x_wdata  in  DATA_W  external write data
x_rdata  out  DATA_W  external read data; valid while x_ack=1
x_ack  out  1  completion pulse for X
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_we  out  1  RAM write enable
mem_rdata  in  DATA_W  RAM read data; valid the cycle after the address is presented
grant_id  out  2  current owner: 0 none, 1 F, 2 D, 3 X
busy  out  1  1 when state != IDLE

Behaviour:
- Reset (async, active-low):
  - State goes to IDLE.
  - All outputs become 0: every *_rdata, every *_ack, mem_addr, mem_wdata, mem_we, grant_id, busy.
  - Starve counter becomes 0.
  - Reset mid-access aborts the access. mem_we drops immediately and no ack is issued.
- States: IDLE -> ISSUE -> RESP -> IDLE. There are no other transitions.
- IDLE:
  - Evaluate the requests at the clock edge.
  - A requester whose ack is high this cycle is masked, so a request held through the ack cycle is never re-granted.
  - Priority: D > F > X. Exception: when starve_cnt == STARVE_LIMIT and x_req=1, X wins.
  - On a winner, latch owner, address, we (F always read) and wdata, then go to ISSUE. Otherwise remain in IDLE.
  - mem_we=0 and grant_id=0 in IDLE. mem_addr and mem_wdata hold their last values.
- ISSUE:
  - mem_addr and mem_wdata are driven from the latches. mem_we is the latched we for exactly this one cycle.
  - grant_id = owner. Next state is RESP.
- RESP:
  - mem_we=0 and grant_id = owner.
  - At the end of the cycle, the owner's ack register is set for one cycle.
  - For reads, the owner's rdata register captures mem_rdata at the same edge. For writes, rdata keeps its previous value.
  - Next state is IDLE.
- Latency: request sampled at edge T (state IDLE), ISSUE in cycle T+1, RESP in T+2, ack high in T+3. Throughput is one access per 3 cycles.
- Ack and rdata:
  - *_ack are registered, mutually exclusive, and exactly 1 cycle wide.
  - *_rdata holds its value until the next read completion for that requester.
- Starve counter (8-bit, saturating at STARVE_LIMIT):
  - Increments at each IDLE arbitration in which x_req=1 and another requester wins.
  - Clears when X is granted or x_req=0.
- Request changes: changes to a non-owner's inputs have no effect. The owner's inputs are latched at grant, so changes after grant are ignored.
- Simultaneous events:
  - New requests arriving while busy wait in place; no request is lost while it is held.
  - The ack of one requester coinciding with another's req is arbitrated normally in that same IDLE cycle.

Test Plan:
- Fetch read: preload RAM[0x0010]=0xBEEF, pulse f_req with f_addr=0x0010 at cycle T -> mem_addr=0x0010 and grant_id=1 at T+1; f_ack=1 and f_rdata=0xBEEF at T+3 only; busy=1 for T+1..T+2.
- Priority: f_req and d_req (load 0x0020=0x1234) raised together and held -> d_ack with 0x1234 first; F is granted in the d_ack cycle and f_ack comes 3 cycles later; no double grant to D.
- Store then load: D writes 0xA5A5 to 0x0030 -> mem_we=1 for exactly one cycle, d_rdata unchanged; D then loads 0x0030 -> d_rdata=0xA5A5.
- Starvation: d_req and f_req held continuously, x_req (read 0x0040) held, STARVE_LIMIT=8 -> X loses 8 arbitrations, then wins the 9th; x_ack arrives within 9*3+3 cycles.
- Reset mid-access: assert reset during an X write in ISSUE -> mem_we falls asynchronously, no ack, all outputs 0; after release with no requests, state stays IDLE and grant_id=0.
- Held request: F holds f_req high through f_ack with no other requests -> exactly one grant per ack, never two accesses per f_ack cycle.
